// File: rtl/fetch_queue_stage.sv
// Decoupled instruction fetch: PC generator, in-order imem request/response port, DEPTH-entry fetch queue.
// Latency: a response is visible on out_* the cycle after it returns (fetch-to-output = mem latency + 1).
// Backpressure: out_ready low holds the head stable; requests stop once queued + in-flight reaches DEPTH.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4,
  output logic [XLEN-1:0] out_instr
);

  // Pointer width indexes DEPTH entries exactly; counters need one more bit to
  // represent "full". The drop counter is wider because stale responses from
  // several back-to-back redirects can pile up while memory is still busy.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = CW + 4;

  // Architectural fetch state
  logic [XLEN-1:0] pc;

  // Fetch queue storage (head entry drives ID directly)
  logic [XLEN-1:0] fq_pc    [DEPTH];
  logic [XLEN-1:0] fq_pc4   [DEPTH];
  logic [XLEN-1:0] fq_instr [DEPTH];
  logic [AW-1:0]   fq_head;
  logic [AW-1:0]   fq_tail;
  logic [CW-1:0]   count;

  // Address tags of requests still waiting for their response, in issue order
  logic [XLEN-1:0] tag_pc   [DEPTH];
  logic [AW-1:0]   tag_head;
  logic [AW-1:0]   tag_tail;
  logic [CW-1:0]   outstanding;

  // Responses still owed by memory for requests that a redirect made stale
  logic [DW-1:0]   drop_cnt;

  // Per-cycle handshake decode
  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_drop;
  logic            rsp_illegal;
  logic            pop;
  logic [CW:0]     inflight;
  logic [DW-1:0]   pending;
  logic [DW-1:0]   drop_after_redirect;
  logic [XLEN-1:0] redirect_target;

  // Next-state values for the control registers
  logic [XLEN-1:0] pc_nxt;
  logic [AW-1:0]   fq_head_nxt;
  logic [AW-1:0]   fq_tail_nxt;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   tag_head_nxt;
  logic [AW-1:0]   tag_tail_nxt;
  logic [CW-1:0]   outstanding_nxt;
  logic [DW-1:0]   drop_cnt_nxt;

  // Credit check: every queued entry plus every in-flight request owns a queue
  // slot, so a response can always be pushed without a full check.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_addr      = pc;

  // Head of the queue goes straight to ID; out_valid is masked during reset
  assign out_valid   = !rst && (count != '0);
  assign out_pc      = fq_pc[fq_head];
  assign out_pcplus4 = fq_pc4[fq_head];
  assign out_instr   = fq_instr[fq_head];

  // Classify this cycle's request, response and pop events
  always_comb begin
    req_fire    = imem_req_valid && imem_req_ready;
    rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
    rsp_accept  = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    rsp_illegal = imem_rsp_valid && (drop_cnt == '0) && (outstanding == '0);
    pop         = out_valid && out_ready;
  end

  // Redirect bookkeeping: everything in flight becomes stale; a response that
  // lands in the redirect cycle itself is one of those and is already gone.
  always_comb begin
    pending             = drop_cnt + DW'(outstanding);
    drop_after_redirect = pending;
    if (imem_rsp_valid && (pending != '0)) begin
      drop_after_redirect = pending - DW'(1);
    end
    // Masking instead of slicing keeps the low address bits forced to zero
    redirect_target = redirect_pc & ~(XLEN'(3));
  end

  // Next-state for PC, pointers and counters; redirect overrides normal flow
  always_comb begin
    pc_nxt          = pc;
    fq_head_nxt     = fq_head;
    fq_tail_nxt     = fq_tail;
    count_nxt       = count;
    tag_head_nxt    = tag_head;
    tag_tail_nxt    = tag_tail;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;

    if (redirect_valid) begin
      pc_nxt          = redirect_target;
      fq_head_nxt     = '0;
      fq_tail_nxt     = '0;
      count_nxt       = '0;
      tag_head_nxt    = '0;
      tag_tail_nxt    = '0;
      outstanding_nxt = '0;
      drop_cnt_nxt    = drop_after_redirect;
    end else begin
      if (req_fire) begin
        pc_nxt       = pc + XLEN'(4);
        tag_tail_nxt = tag_tail + 1'b1;
      end
      if (rsp_accept) begin
        tag_head_nxt = tag_head + 1'b1;
        fq_tail_nxt  = fq_tail + 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt_nxt = drop_cnt - DW'(1);
      end
      if (pop) begin
        fq_head_nxt = fq_head + 1'b1;
      end
      count_nxt       = count + CW'(rsp_accept) - CW'(pop);
      outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_accept);
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fq_head     <= '0;
      fq_tail     <= '0;
      count       <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      pc          <= pc_nxt;
      fq_head     <= fq_head_nxt;
      fq_tail     <= fq_tail_nxt;
      count       <= count_nxt;
      tag_head    <= tag_head_nxt;
      tag_tail    <= tag_tail_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // Payload storage needs no reset: entries are only read once count covers them
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_tail] <= pc;
    end
    if (rsp_accept) begin
      fq_pc[fq_tail]    <= tag_pc[tag_head];
      fq_pc4[fq_tail]   <= tag_pc[tag_head] + XLEN'(4);
      fq_instr[fq_tail] <= imem_rsp_data;
    end
  end

  // Memory returning data with nothing outstanding and nothing to drop is a protocol error
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!rsp_illegal);
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage: behavioural memory + program-order reference model.
// Stimulus pushes expected PCs on each accepted request; a separate monitor pops them on every ID pop.
// Memory latency, request/ID readiness and redirects are randomized per phase.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;

  fetch_queue_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // In-flight memory transaction: address, redirect epoch it belongs to, cycle it may return
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];   // issued PCs since last flush, in program order
  int          arrived;    // how many of exp_q have their instruction back (front entries)
  int          epoch;
  int          cyc;
  int          checks;
  int          errors;
  int          fires;
  logic [31:0] model_pc;

  // Stimulus knobs
  int          lat;
  int          ready_pct;
  int          oready_pct;
  int          redir_pct;
  bit          rst_req;
  bit          force_redir;
  logic [31:0] force_tgt;
  bit          redir_busy;
  bit          busy_hit;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, record handshakes, then update the model
  task automatic step();
    bit   rsp_now;
    bit   redir_now;
    bit   stale;
    mem_t head;
    rsp_now = 1'b0;
    stale   = 1'b0;
    @(negedge clk);
    rst = rst_req;
    if (rst_req) mem_q.delete();
    rsp_now        = !rst_req && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(mem_q[0].addr) : $urandom();
    imem_req_ready = ($urandom_range(99) < ready_pct);
    out_ready      = ($urandom_range(99) < oready_pct);
    redir_now      = !rst_req && (force_redir || ($urandom_range(99) < redir_pct) ||
                                  (redir_busy && rsp_now && out_valid && out_ready));
    if (redir_now && redir_busy && rsp_now && out_valid && out_ready) begin
      busy_hit   = 1'b1;
      redir_busy = 1'b0;
    end
    redirect_valid = redir_now;
    redirect_pc    = force_redir ? force_tgt : $urandom();
    force_redir    = 1'b0;
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'(!rst_req && !redir_now && (exp_q.size() < DEPTH)));
    if (!rst_req) chk("imem_addr", imem_addr, model_pc);
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{imem_addr, epoch, cyc + lat});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      fires++;
    end
    if (rsp_now) begin
      head  = mem_q.pop_front();
      stale = (head.epoch != epoch);
    end
    #2;
    if (rst_req) begin
      epoch++;
      exp_q.delete();
      arrived  = 0;
      model_pc = RESET_PC;
    end else if (redir_now) begin
      epoch++;
      exp_q.delete();
      arrived  = 0;
      model_pc = redirect_pc & ~32'h3;
    end else if (rsp_now && !stale) begin
      arrived++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: checks out_valid every cycle and the head contents on every pop
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", 32'(out_valid), 32'(!rst && (arrived > 0)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow: got pop of pc %h expected no entry (cycle %0d)", out_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_pcplus4", out_pcplus4, e + 32'd4);
          chk("out_instr", out_instr, instr_of(e));
          if (arrived > 0) arrived--;
        end
      end
    end
  end

  initial begin
    int f0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    arrived = 0; epoch = 0; cyc = 0; checks = 0; errors = 0; fires = 0; model_pc = RESET_PC;
    lat = 1; ready_pct = 100; oready_pct = 100; redir_pct = 0;
    rst_req = 1'b1; force_redir = 1'b0; force_tgt = '0; redir_busy = 1'b0; busy_hit = 1'b0;

    // Reset, then steady stream with 1-cycle memory
    run(3);
    rst_req = 1'b0;
    run(40);

    // Stall from reset: exactly DEPTH requests, head stays at RESET_PC, then drain
    rst_req = 1'b1; run(1); rst_req = 1'b0;
    oready_pct = 0;
    f0 = fires;
    run(10);
    chk("stall_fires", 32'(fires - f0), 32'(DEPTH));
    chk("stall_head_pc", out_pc, RESET_PC);
    oready_pct = 100;
    run(15);

    // 3-cycle memory, redirect to an unaligned target with requests in flight
    lat = 3;
    run(3);
    force_redir = 1'b1; force_tgt = 32'h0000_0103;
    run(25);

    // Redirect in a cycle that also carries a response and a pop
    lat = 2;
    redir_busy = 1'b1;
    run(60);
    chk("busy_redirect_hit", 32'(busy_hit), 32'd1);
    redir_busy = 1'b0;
    run(10);

    // PC wrap with randomly toggling request ready
    lat = 1; ready_pct = 50; oready_pct = 70;
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    run(30);

    // Fully randomized mix of latency, readiness and redirects
    redir_pct = 5;
    for (int b = 0; b < 8; b++) begin
      lat        = $urandom_range(4, 1);
      ready_pct  = $urandom_range(100, 40);
      oready_pct = $urandom_range(100, 20);
      run(60);
    end
    redir_pct = 0;

    // Reset mid-stream with entries queued
    lat = 1; ready_pct = 100; oready_pct = 0;
    run(8);
    rst_req = 1'b1; run(1); rst_req = 1'b0;
    oready_pct = 100;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-cycle IF stage.
- Decouples PC generation from decode through an in-order request/response instruction-memory interface and a DEPTH-entry fetch queue.
- Supports multiple outstanding fetches, redirect (branch/jump) with discard of stale responses, and valid/ready backpressure toward ID.
- Sits between pc/redirect logic in EX and the IF/ID boundary.

Parameters:
XLEN, 32, address and instruction width.
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 4, fetch-queue entries and maximum outstanding requests (power of 2, >=2).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  pctarget valid this cycle (taken branch/jump)
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored, treated as 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address (current PC)
imem_rsp_valid  input  1  instruction data returned, in request order
imem_rsp_data  input  XLEN  instruction word
out_valid  output  1  queue head valid to ID
out_ready  input  1  ID accepts head (low = stall)
out_pc  output  XLEN  head PC
out_pcplus4  output  XLEN  head PC + 4
out_instr  output  XLEN  head instruction

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0. While rst is high: imem_req_valid=0, out_valid=0. Reset mid-operation discards everything, and responses arriving after reset are ignored only if drop_cnt=0 (memory must also be reset).
- Credits: a request issues when imem_req_valid && imem_req_ready.
  - imem_req_valid = !rst && !redirect_valid && (count + outstanding) < DEPTH.
- imem_addr = pc. On an accepted request:
  - pc <= pc + 4, wrapping mod 2^XLEN;
  - the request PC is pushed to an internal DEPTH-entry address tag queue;
  - outstanding increments.
- Response (imem_rsp_valid):
  - If drop_cnt>0: drop_cnt decrements and the data is discarded.
  - Otherwise: pop the tag queue, push {tag_pc, tag_pc+4, data} into the fetch queue, and decrement outstanding.
  - Credits guarantee the queue is never full on a push.
  - A response with outstanding=0 and drop_cnt=0 is illegal: ignore it and flag via a simulation assertion.
- Output:
  - out_valid = count>0.
  - out_* driven combinationally from head storage.
  - Pop when out_valid && out_ready.
  - out_* holds stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged, pointers both advance. Pointer wrap mod DEPTH.
- Redirect (highest priority, in the cycle redirect_valid=1):
  - No request is issued.
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue and tag queue are flushed (count=0).
  - drop_cnt <= drop_cnt + outstanding − (1 if a response arrives this cycle).
  - outstanding <= 0.
  - out_valid still reflects pre-redirect contents this cycle. A pop in that cycle is permitted; EX is responsible for squashing it.
- First request after redirect: next cycle, addr=redirect target.
- Latency: the request at pc reaches out_valid the cycle after its response. Minimum fetch-to-output is mem latency + 1.
- Steady state with 1-cycle memory and out_ready=1 sustains one instruction per cycle.

Test Plan:
- Reset release, RESET_PC=0x0, 1-cycle memory, out_ready=1 -> imem_addr 0x0,0x4,0x8... on consecutive cycles. out_pc 0x0 appears 2 cycles after first request, then one per cycle; out_pcplus4=out_pc+4.
- out_ready held 0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0. out_pc stays 0x0. On release, 0x0,0x4,0x8,0xC drain and fetching resumes at 0x10.
- 3-cycle memory latency with 3 outstanding (addrs 0x10,0x14,0x18), then redirect to 0x103 -> next request addr 0x100. The 3 stale responses are dropped. First out_pc=0x100 with the instruction returned for 0x100.
- Redirect in the same cycle as a response and a pop -> drop_cnt = outstanding−1, queue empty the next cycle, no stale PC ever output.
- imem_req_ready toggled randomly, pc near 0xFFFF_FFF8 -> order 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 is preserved with no duplicates or gaps.
- rst asserted mid-stream with 2 entries queued -> next cycle out_valid=0, imem_addr=RESET_PC, and the queue is empty.
